atm_core_param: RTL

//  Clocked, parametrised ATM transaction controller. Holds per-account balance, PIN and

---
 rtl/atm_core_param.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/atm_core_param.sv
// ATM transaction controller: card/PIN auth, lockout, idle timeout and
// checked balance arithmetic. Ports: card/pin/op requests in; balance,
// current_state and a done/error_code handshake out.
module atm_core_param #(
  parameter int NUM_ACC     = 10,
  parameter int ACC_W       = 4,
  parameter int PIN_W       = 16,
  parameter int BAL_W       = 16,
  parameter int INIT_BAL    = 500,
  parameter logic [PIN_W-1:0] INIT_PIN = PIN_W'(16'h1234),
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             card_in,
  input  logic [ACC_W-1:0] acc_num,
  input  logic [PIN_W-1:0] pin,
  input  logic             pin_valid,
  input  logic             op_valid,
  input  logic [2:0]       operation,
  input  logic [BAL_W-1:0] amount,
  input  logic [PIN_W-1:0] new_pin,
  output logic [BAL_W-1:0] balance,
  output logic [2:0]       current_state,
  output logic             done,
  output logic [2:0]       error_code
);

  localparam int TRW = $clog2(MAX_TRIES + 1);
  localparam int TMW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_WAIT = 3'd0,
    S_AUTH = 3'd1,
    S_MENU = 3'd2,
    S_EXEC = 3'd3,
    S_LOCK = 3'd4
  } state_e;

  localparam logic [2:0] E_OK   = 3'd0;
  localparam logic [2:0] E_PIN  = 3'd1;
  localparam logic [2:0] E_ACC  = 3'd2;
  localparam logic [2:0] E_LOCK = 3'd3;
  localparam logic [2:0] E_NSF  = 3'd4;
  localparam logic [2:0] E_OVF  = 3'd5;
  localparam logic [2:0] E_OP   = 3'd6;
  localparam logic [2:0] E_TMO  = 3'd7;

  state_e state_q, state_d;

  logic [ACC_W-1:0] acc_q;
  logic [PIN_W-1:0] pin_q;
  logic [2:0]       op_q;
  logic [BAL_W-1:0] amt_q;
  logic [PIN_W-1:0] npin_q;

  logic [BAL_W-1:0] bal_mem [NUM_ACC];
  logic [PIN_W-1:0] pin_mem [NUM_ACC];
  logic [TRW-1:0]   try_mem [NUM_ACC];
  logic [NUM_ACC-1:0] lock_q;

  logic [BAL_W-1:0] bal_q, bal_d;
  logic             done_q, done_d;
  logic [2:0]       err_q, err_d;
  logic [TMW-1:0]   idle_q, idle_d;

  logic             acc_ok;
  logic [ACC_W-1:0] idx;
  logic [BAL_W-1:0] cur_bal;
  logic [PIN_W-1:0] cur_pin;
  logic [TRW-1:0]   cur_try;
  logic             cur_lock;
  logic [BAL_W:0]   sum;

  logic             lat_pin, lat_op;
  logic             bal_we, pin_we, try_we, lock_set;
  logic [BAL_W-1:0] bal_wd;
  logic [TRW-1:0]   try_wd;

  // out-of-range accounts are redirected to entry 0 but never acted on
  assign acc_ok   = {1'b0, acc_q} < (ACC_W+1)'(NUM_ACC);
  assign idx      = acc_ok ? acc_q : '0;
  assign cur_bal  = bal_mem[idx];
  assign cur_pin  = pin_mem[idx];
  assign cur_try  = try_mem[idx];
  assign cur_lock = lock_q[idx];
  assign sum      = {1'b0, cur_bal} + {1'b0, amt_q};

  always_comb begin
    state_d  = state_q;
    bal_d    = bal_q;
    done_d   = 1'b0;
    err_d    = err_q;
    idle_d   = idle_q;
    lat_pin  = 1'b0;
    lat_op   = 1'b0;
    bal_we   = 1'b0;
    bal_wd   = cur_bal;
    pin_we   = 1'b0;
    try_we   = 1'b0;
    try_wd   = cur_try;
    lock_set = 1'b0;
    unique case (state_q)
      S_WAIT: begin
        if (pin_valid && card_in) begin
          lat_pin = 1'b1;
          state_d = S_AUTH;
        end
      end
      S_AUTH: begin
        if (!card_in) begin
          state_d = S_WAIT;
          bal_d   = '0;
        end else if (!acc_ok) begin
          done_d  = 1'b1;
          err_d   = E_ACC;
          state_d = S_WAIT;
        end else if (cur_lock) begin
          done_d  = 1'b1;
          err_d   = E_LOCK;
          state_d = S_LOCK;
        end else if (pin_q == cur_pin) begin
          done_d  = 1'b1;
          err_d   = E_OK;
          try_we  = 1'b1;
          try_wd  = '0;
          idle_d  = '0;
          state_d = S_MENU;
        end else begin
          done_d  = 1'b1;
          try_we  = 1'b1;
          try_wd  = cur_try + TRW'(1);
          if (cur_try == TRW'(MAX_TRIES - 1)) begin
            lock_set = 1'b1;
            err_d    = E_LOCK;
            state_d  = S_LOCK;
          end else begin
            err_d    = E_PIN;
            state_d  = S_WAIT;
          end
        end
      end
      S_MENU: begin
        if (!card_in) begin
          state_d = S_WAIT;
          bal_d   = '0;
        end else if (op_valid) begin
          lat_op  = 1'b1;
          idle_d  = '0;
          state_d = S_EXEC;
        end else if (idle_q == TMW'(TIMEOUT_CYC - 1)) begin
          done_d  = 1'b1;
          err_d   = E_TMO;
          idle_d  = '0;
          state_d = S_WAIT;
        end else begin
          idle_d  = idle_q + TMW'(1);
        end
      end
      S_EXEC: begin
        if (!card_in) begin
          // card pulled mid-operation: drop it silently
          state_d = S_WAIT;
          bal_d   = '0;
        end else begin
          done_d  = 1'b1;
          err_d   = E_OK;
          state_d = S_MENU;
          bal_d   = cur_bal;
          case (op_q)
            3'd1: ;
            3'd2: begin
              if (amt_q > cur_bal) begin
                err_d = E_NSF;
              end else begin
                bal_we = 1'b1;
                bal_wd = cur_bal - amt_q;
                bal_d  = cur_bal - amt_q;
              end
            end
            3'd3: begin
              if (sum[BAL_W]) begin
                err_d = E_OVF;
              end else begin
                bal_we = 1'b1;
                bal_wd = sum[BAL_W-1:0];
                bal_d  = sum[BAL_W-1:0];
              end
            end
            3'd4: pin_we = 1'b1;
            3'd5: state_d = S_WAIT;
            default: err_d = E_OP;
          endcase
        end
      end
      S_LOCK: begin
        if (!card_in) state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      bal_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= E_OK;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      bal_q   <= bal_d;
      done_q  <= done_d;
      err_q   <= err_d;
      idle_q  <= idle_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      pin_q  <= '0;
      op_q   <= '0;
      amt_q  <= '0;
      npin_q <= '0;
      lock_q <= '0;
      for (int i = 0; i < NUM_ACC; i++) begin
        bal_mem[i] <= BAL_W'(INIT_BAL);
        pin_mem[i] <= INIT_PIN;
        try_mem[i] <= '0;
      end
    end else begin
      if (lat_pin) begin
        acc_q <= acc_num;
        pin_q <= pin;
      end
      if (lat_op) begin
        op_q   <= operation;
        amt_q  <= amount;
        npin_q <= new_pin;
      end
      if (bal_we)   bal_mem[idx] <= bal_wd;
      if (pin_we)   pin_mem[idx] <= npin_q;
      if (try_we)   try_mem[idx] <= try_wd;
      if (lock_set) lock_q[idx]  <= 1'b1;
    end
  end

  assign balance       = bal_q;
  assign current_state = state_q;
  assign done          = done_q;
  assign error_code    = err_q;

endmodule
